pfb_input_stream_tx: RTL and testbench
======================================

# pfb_input_stream_tx

Transmit-side stream fork that feeds the PFB multichannel input reader.
- Accepts one wide sample word per handshake from the capture front end.
- Fans the word out onto NCHAN parallel AXI-Stream master channels in lockstep, with `tlast` marking frame boundaries every FRAME_LEN beats.
- Exports per-channel registered block flags and a stall watchdog, so deadlock diagnosis can be done from the producer side of the same streams.

## Interface
Parameters:
- DATA_W, 32, bits per channel sample (packed 16-bit I/Q)
- NCHAN, 8, number of output AXIS channels
- FRAME_LEN, 1024, beats per frame; power of two, minimum 2
- STALL_LIMIT, 4096, consecutive stalled cycles before `timeout` asserts; minimum 1

Ports:
- clock  in  1  single clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  permits acceptance of new input words
- frame_restart  in  1  single-cycle pulse; realigns beat counter to 0
- clear_timeout  in  1  clears sticky `timeout`
- s_valid  in  1  input word valid
- s_ready  out  1  input word accepted when `s_valid & s_ready`
- s_data  in  NCHAN*DATA_W  packed samples; channel i = bits [i*DATA_W +: DATA_W]
- m_tvalid  out  NCHAN  per-channel valid
- m_tready  in  NCHAN  per-channel ready
- m_tdata  out  NCHAN*DATA_W  per-channel data, same packing as `s_data`
- m_tlast  out  NCHAN  per-channel last; all bits equal while valid
- axis_block  out  NCHAN  registered `m_tvalid[i] & ~m_tready[i]`
- frame_count  out  32  completed frames accepted, wraps modulo 2^32
- timeout  out  1  sticky stall-watchdog flag

## Operation
- Holding state:
  - `data_q` holds the current word; `last_q` holds its last flag.
  - `pending[NCHAN]` marks channels not yet handshaked. `m_tvalid = pending`, `m_tdata = data_q`, `m_tlast = {NCHAN{last_q}}`.
- Channel i completes on `pending[i] & m_tready[i]`, which clears `pending[i]`.
- Acceptance rule:
  - `s_ready = enable & ((pending & ~m_tready) == 0)`, i.e. every still-pending channel completes this cycle.
  - This is combinational from `m_tready`; no combinational path from `s_valid` to `s_ready`.
- On accept:
  - `data_q <= s_data`, `pending <= all ones`, `last_q <= (beat == FRAME_LEN-1)`.
  - `beat` increments modulo FRAME_LEN.
  - If `last_q` was set on the word just accepted, `frame_count` increments one cycle later.
- Channels may complete in any order. A new word is never presented until all channels took the previous one, so no channel ever skips or duplicates a word.
- `frame_restart`:
  - Sets `beat` to 0.
  - If it coincides with an accept, the accepted word uses beat 0 and `beat` becomes 1.
  - It does not affect pending data.
- `enable` low:
  - `s_ready = 0`; pending channels still drain normally.
  - `beat` and `frame_count` hold.
- Watchdog:
  - `stall_cnt` increments each cycle with `pending != 0` and no channel handshake.
  - It resets to 0 on any channel handshake or when `pending == 0`, and saturates at STALL_LIMIT.
  - `timeout` sets when `stall_cnt` reaches STALL_LIMIT and stays set until `clear_timeout`. If clear and set occur in the same cycle, set wins.

## Timing
- Reset values (async on `reset_n` low):
  - `pending`, `m_tvalid`, `m_tlast`, `m_tdata`, `data_q` = 0
  - `beat`, `frame_count`, `stall_cnt` = 0
  - `axis_block`, `timeout` = 0
  - `s_ready` forced 0 while `reset_n` is low.
- Reset mid-frame discards the held word; the first word after reset is beat 0.
- Latency: accept in cycle N → `m_tvalid` high in cycle N+1.
- Throughput: one word per cycle sustained when all `m_tready` are high.
- AXIS rule: once `m_tvalid[i]` is high, `m_tdata`/`m_tlast` stay stable until that channel handshakes.
- `axis_block` lags the wire condition by one cycle.
- `frame_count` updates one cycle after accepting a last word.
- `timeout` is first high STALL_LIMIT+1 cycles after the first stalled cycle.

## Test plan
- Reset check: `reset_n` low with random inputs → all outputs 0, `s_ready` 0. Release, `enable`=1, `s_valid`=1 → first `m_tvalid`=all ones one cycle later.
- Full-rate framing: FRAME_LEN=4, NCHAN=8, all ready, 12 words 0..11 → each channel receives 12 beats in order, `m_tlast` on words 3/7/11, `frame_count`=3, `s_ready` never low.
- Skewed channels: channel 2 `m_tready` low for 5 cycles → `s_ready` low for those cycles, other channels take word once, `axis_block[2]` high for 5 cycles one cycle delayed, no duplicate or skipped words.
- Watchdog: STALL_LIMIT=8, all `m_tready` low with pending word → `timeout` rises on cycle 9. Release ready → `timeout` stays high until `clear_timeout`; clear concurrent with a new saturation → stays high.
- Restart/enable: `frame_restart` pulsed at beat 2 concurrent with accept → that word is beat 0, `tlast` on the 4th word after. `enable` low mid-frame → drain completes, `beat` holds.
- Async reset mid-frame with pending word → outputs clear immediately; next frame starts at beat 0, `frame_count` 0.

Source files
------------

// File: rtl/pfb_input_stream_tx.sv
// rtl/pfb_input_stream_tx.sv - lockstep fan-out of one wide sample word onto NCHAN AXIS channels
`timescale 1ns/1ps
module pfb_input_stream_tx #(
    parameter int DATA_W      = 32,
    parameter int NCHAN       = 8,
    parameter int FRAME_LEN   = 1024,
    parameter int STALL_LIMIT = 4096
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    frame_restart,
    input  logic                    clear_timeout,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [NCHAN*DATA_W-1:0] s_data,
    output logic [NCHAN-1:0]        m_tvalid,
    input  logic [NCHAN-1:0]        m_tready,
    output logic [NCHAN*DATA_W-1:0] m_tdata,
    output logic [NCHAN-1:0]        m_tlast,
    output logic [NCHAN-1:0]        axis_block,
    output logic [31:0]             frame_count,
    output logic                    timeout
);

    localparam int BEAT_W  = $clog2(FRAME_LEN);
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);
    localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(FRAME_LEN - 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);

    logic [NCHAN-1:0]        pending;
    logic [NCHAN*DATA_W-1:0] data_q;
    logic                    last_q;
    logic [BEAT_W-1:0]       beat;
    logic [BEAT_W-1:0]       cur_beat;
    logic                    frame_inc;
    logic [STALL_W-1:0]      stall_cnt;
    logic [NCHAN-1:0]        blocked;
    logic [NCHAN-1:0]        handshake;
    logic                    accept;
    logic                    stalled;

    // Channels still holding the word and not taking it this cycle gate acceptance.
    assign blocked   = pending & ~m_tready;
    assign handshake = pending & m_tready;
    assign s_ready   = reset_n & enable & (blocked == '0);
    assign accept    = s_valid & s_ready;
    assign cur_beat  = frame_restart ? '0 : beat;
    assign stalled   = (pending != '0) & (handshake == '0);

    assign m_tvalid = pending;
    assign m_tdata  = data_q;
    assign m_tlast  = {NCHAN{last_q}};

    // Holding register, per-channel pending mask and beat position within the frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            beat    <= '0;
        end else if (accept) begin
            pending <= '1;
            data_q  <= s_data;
            last_q  <= (cur_beat == LAST_BEAT);
            beat    <= cur_beat + BEAT_W'(1);
        end else begin
            pending <= pending & ~m_tready;
            if (frame_restart) begin
                beat <= '0;
            end
        end
    end

    // Frame counter advances the cycle after a frame-closing word is accepted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            frame_inc   <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_inc <= accept & (cur_beat == LAST_BEAT);
            if (frame_inc) begin
                frame_count <= frame_count + 32'd1;
            end
        end
    end

    // Stall watchdog: saturating run length of no-progress cycles, sticky timeout where set beats clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            timeout   <= 1'b0;
        end else begin
            if (!stalled) begin
                stall_cnt <= '0;
            end else if (stall_cnt != STALL_MAX) begin
                stall_cnt <= stall_cnt + STALL_W'(1);
            end
            timeout <= (stall_cnt == STALL_MAX) | (timeout & ~clear_timeout);
        end
    end

    // Registered per-channel back-pressure flags for producer-side deadlock diagnosis.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            axis_block <= '0;
        end else begin
            axis_block <= blocked;
        end
    end

endmodule

// File: tb/tb_pfb_input_stream_tx.sv
// tb/tb_pfb_input_stream_tx.sv - self-checking bench for pfb_input_stream_tx
`timescale 1ns/1ps
module tb_pfb_input_stream_tx;

    localparam int DW  = 32;
    localparam int NCH = 8;
    localparam int FL  = 4;
    localparam int SL  = 8;

    logic                clock;
    logic                reset_n;
    logic                enable;
    logic                frame_restart;
    logic                clear_timeout;
    logic                s_valid;
    logic                s_ready;
    logic [NCH*DW-1:0]   s_data;
    logic [NCH-1:0]      m_tvalid;
    logic [NCH-1:0]      m_tready;
    logic [NCH*DW-1:0]   m_tdata;
    logic [NCH-1:0]      m_tlast;
    logic [NCH-1:0]      axis_block;
    logic [31:0]         frame_count;
    logic                timeout;

    pfb_input_stream_tx #(.DATA_W(DW), .NCHAN(NCH), .FRAME_LEN(FL), .STALL_LIMIT(SL)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .frame_restart(frame_restart),
        .clear_timeout(clear_timeout), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .axis_block(axis_block), .frame_count(frame_count), .timeout(timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [NCH*DW-1:0] data;
        bit                last;
    } word_t;

    typedef struct {
        bit           en;
        bit           vld;
        logic [7:0]   rdy;
        bit           exp_sready;
        logic [7:0]   exp_tvalid;
        logic [7:0]   exp_block;
    } row_t;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: every accepted word is logged; each channel walks the log at its own pace.
    word_t      word_log[$];
    int         rx_idx[NCH];
    int         mbeat;
    int         exp_frames;
    int         pend_frame;
    int         run;
    bit         exp_to;
    logic [NCH-1:0] exp_block;

    bit         obs_sready;
    bit         obs_to;
    logic [NCH-1:0] obs_tvalid;
    logic [NCH-1:0] obs_block;
    bit         obs_last[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < NCH; ch++) rx_idx[ch] = word_log.size();
        mbeat = 0; exp_frames = 0; pend_frame = 0; run = 0; exp_to = 0; exp_block = '0;
    endtask

    task automatic rand_data();
        for (int ch = 0; ch < NCH; ch++) s_data[ch*DW +: DW] = $urandom;
    endtask

    // One clock cycle: compare outputs against the model mid-cycle, then advance the model at the edge.
    task automatic step();
        logic [NCH-1:0] ev;
        logic [NCH-1:0] hs;
        bit esr, acc, stalled, lst;
        int b;
        word_t w;
        @(negedge clock);
        for (int ch = 0; ch < NCH; ch++) ev[ch] = (rx_idx[ch] < word_log.size());
        esr = enable;
        for (int ch = 0; ch < NCH; ch++) if (ev[ch] && !m_tready[ch]) esr = 0;
        obs_sready = s_ready; obs_to = timeout; obs_tvalid = m_tvalid; obs_block = axis_block;
        chk("s_ready", s_ready, esr);
        chk("m_tvalid", m_tvalid, ev);
        chk("axis_block", axis_block, exp_block);
        chk("frame_count", frame_count, exp_frames);
        chk("timeout", timeout, exp_to);
        for (int ch = 0; ch < NCH; ch++) begin
            if (ev[ch]) begin
                w = word_log[rx_idx[ch]];
                chk($sformatf("tdata[%0d]", ch), m_tdata[ch*DW +: DW], w.data[ch*DW +: DW]);
                chk($sformatf("tlast[%0d]", ch), m_tlast[ch], w.last);
            end
        end
        if (m_tvalid[0] && m_tready[0]) obs_last.push_back(m_tlast[0]);
        hs = ev & m_tready;
        acc = s_valid && esr;
        stalled = (ev != '0) && (hs == '0);
        @(posedge clock);
        exp_block = ev & ~m_tready;
        exp_to = (run >= SL) || (exp_to && !clear_timeout);
        run = stalled ? run + 1 : 0;
        exp_frames += pend_frame;
        pend_frame = 0;
        for (int ch = 0; ch < NCH; ch++) if (hs[ch]) rx_idx[ch]++;
        if (acc) begin
            b = frame_restart ? 0 : mbeat;
            lst = (b == FL - 1);
            w.data = s_data;
            w.last = lst;
            word_log.push_back(w);
            mbeat = (b + 1) % FL;
            if (lst) pend_frame = 1;
        end else if (frame_restart) begin
            mbeat = 0;
        end
        #1;
    endtask

    // Asynchronous reset asserted away from any clock edge, with busy random inputs.
    task automatic do_reset();
        @(posedge clock);
        #3;
        reset_n = 0;
        enable = 1; s_valid = 1; m_tready = NCH'($urandom); rand_data();
        frame_restart = 1'($urandom); clear_timeout = 1'($urandom);
        model_reset();
        #1;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tdata", |m_tdata, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_axis_block", axis_block, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_timeout", timeout, 0);
        repeat (2) @(posedge clock);
        #1;
        enable = 1; s_valid = 0; m_tready = '1; frame_restart = 0; clear_timeout = 0;
        reset_n = 1;
    endtask

    function automatic logic [63:0] last_vec();
        logic [63:0] v = '0;
        foreach (obs_last[i]) if (i < 64) v[i] = obs_last[i];
        return v;
    endfunction

    row_t tbl[14];

    initial begin
        int first;
        int low_cnt;
        reset_n = 0; enable = 0; frame_restart = 0; clear_timeout = 0; s_valid = 0;
        m_tready = '0; s_data = '0;

        tbl[0]  = '{1, 1, 8'hFF, 1, 8'h00, 8'h00};
        tbl[1]  = '{1, 1, 8'hFB, 0, 8'hFF, 8'h00};
        tbl[2]  = '{1, 1, 8'hFB, 0, 8'h04, 8'h04};
        tbl[3]  = '{1, 1, 8'hFB, 0, 8'h04, 8'h04};
        tbl[4]  = '{1, 1, 8'hFB, 0, 8'h04, 8'h04};
        tbl[5]  = '{1, 1, 8'hFB, 0, 8'h04, 8'h04};
        tbl[6]  = '{1, 1, 8'hFF, 1, 8'h04, 8'h04};
        tbl[7]  = '{1, 1, 8'hFF, 1, 8'hFF, 8'h00};
        tbl[8]  = '{0, 1, 8'hFF, 0, 8'hFF, 8'h00};
        tbl[9]  = '{0, 1, 8'hFF, 0, 8'h00, 8'h00};
        tbl[10] = '{1, 0, 8'h00, 1, 8'h00, 8'h00};
        tbl[11] = '{1, 1, 8'h00, 1, 8'h00, 8'h00};
        tbl[12] = '{1, 1, 8'h00, 0, 8'hFF, 8'h00};
        tbl[13] = '{1, 1, 8'h00, 0, 8'hFF, 8'hFF};

        // Reset, first-word latency and skewed channel 2
        do_reset();
        for (int i = 0; i < 14; i++) begin
            enable = tbl[i].en; s_valid = tbl[i].vld; m_tready = tbl[i].rdy; rand_data();
            step();
            chk($sformatf("tbl%0d_s_ready", i), obs_sready, tbl[i].exp_sready);
            chk($sformatf("tbl%0d_tvalid", i), obs_tvalid, tbl[i].exp_tvalid);
            chk($sformatf("tbl%0d_block", i), obs_block, tbl[i].exp_block);
        end

        // Full-rate framing: 12 words, all channels ready
        do_reset();
        obs_last.delete();
        low_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            s_valid = 1;
            for (int ch = 0; ch < NCH; ch++) s_data[ch*DW +: DW] = DW'(k * 16 + ch);
            step();
            if (!obs_sready) low_cnt++;
        end
        s_valid = 0;
        repeat (3) step();
        chk("fullrate_lasts", last_vec(), 64'h888);
        chk("fullrate_frames", frame_count, 3);
        chk("fullrate_ready_low", low_cnt, 0);

        // Restart concurrent with accept at beat 2, then enable low mid-frame
        obs_last.delete();
        for (int k = 0; k < 6; k++) begin
            s_valid = 1; rand_data(); frame_restart = (k == 2);
            step();
        end
        frame_restart = 0;
        step();
        enable = 0; m_tready = 8'hF0;
        step();
        m_tready = '1;
        repeat (2) step();
        enable = 1;
        for (int k = 0; k < 3; k++) begin
            rand_data();
            step();
        end
        s_valid = 0;
        repeat (3) step();
        chk("restart_lasts", last_vec(), 64'h220);

        // Watchdog latency, stickiness, clear, and set winning over clear
        s_valid = 1; m_tready = '1; rand_data();
        step();
        s_valid = 0; m_tready = '0;
        first = -1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (obs_to && first < 0) first = i;
        end
        chk("timeout_latency", first, SL + 1);
        m_tready = '1;
        repeat (3) step();
        chk("timeout_sticky", obs_to, 1);
        clear_timeout = 1;
        step();
        clear_timeout = 0;
        step();
        chk("timeout_cleared", obs_to, 0);
        clear_timeout = 1; s_valid = 1; rand_data();
        step();
        s_valid = 0; m_tready = '0;
        first = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (obs_to && first < 0) first = i;
        end
        chk("timeout_set_wins_latency", first, SL + 1);
        chk("timeout_set_wins_hold", obs_to, 1);
        clear_timeout = 0; m_tready = '1;
        repeat (2) step();
        clear_timeout = 1;
        step();
        clear_timeout = 0;

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            enable = ($urandom_range(0, 9) != 0);
            s_valid = ($urandom_range(0, 3) != 0);
            m_tready = NCH'($urandom | $urandom);
            if ((i % 250) >= 238) m_tready = '0;
            frame_restart = ($urandom_range(0, 39) == 0);
            clear_timeout = ($urandom_range(0, 19) == 0);
            rand_data();
            step();
        end
        enable = 1; frame_restart = 0; clear_timeout = 0;

        // Async reset mid-frame with a pending word
        s_valid = 1; m_tready = '1; rand_data();
        step();
        m_tready = '0;
        repeat (2) step();
        do_reset();
        obs_last.delete();
        for (int k = 0; k < 4; k++) begin
            s_valid = 1; rand_data();
            step();
        end
        s_valid = 0;
        repeat (2) step();
        chk("post_reset_lasts", last_vec(), 64'h8);
        chk("post_reset_frames", frame_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_time_limit: actual=expired required=finished");
        $fatal(1);
    end

endmodule
